// File: rtl/bsg_pipe_dff_pkg.sv
// Shared helpers for the bsg_pipe_dff pipeline register chain.
// The per-stage state struct is declared in bsg_pipe_dff_stage, where width_p is known.
package bsg_pipe_dff_pkg;

    localparam int unsigned width_default_gp = 27;
    localparam int unsigned depth_default_gp = 3;

    // Bits needed to hold an occupancy of 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/bsg_pipe_dff_if.sv
// Valid/ready/yumi handshake bundle for bsg_pipe_dff; slave is the pipeline side.
interface bsg_pipe_dff_if #(
    parameter int width_p = 27,
    parameter int depth_p = 3
);
    localparam int count_w_lp = bsg_pipe_dff_pkg::count_width(depth_p);

    logic                  v_i;
    logic [width_p-1:0]    data_i;
    logic                  ready_o;
    logic                  v_o;
    logic [width_p-1:0]    data_o;
    logic                  yumi_i;
    logic [count_w_lp-1:0] count_o;

    modport slave (
        input  v_i, data_i, yumi_i,
        output ready_o, v_o, data_o, count_o
    );

    modport master (
        output v_i, data_i, yumi_i,
        input  ready_o, v_o, data_o, count_o
    );
endinterface

// File: rtl/bsg_pipe_dff_chk.sv
// Protocol and occupancy checks for bsg_pipe_dff (simulation-only behaviour).
module bsg_pipe_dff_chk #(
    parameter int depth_p   = 3,
    parameter int count_w_p = 2
) (
    input logic                 clk_i,
    input logic                 reset_n_i,
    input logic                 yumi_i,
    input logic                 v_o,
    input logic [depth_p-1:0]   v_vec_i,
    input logic [count_w_p-1:0] count_i
);
    a_yumi_needs_valid: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) yumi_i |-> v_o
    );

    a_count_is_popcount: assert property (
        @(posedge clk_i) disable iff (!reset_n_i) $countones(v_vec_i) == int'(count_i)
    );
endmodule

// File: rtl/bsg_pipe_dff_stage.sv
// One pipeline stage: valid bit plus data register with bubble-collapsing advance.
// Optional flush input exists only when BSG_PIPE_DFF_FLUSH_EN is defined.
module bsg_pipe_dff_stage #(
    parameter int width_p = 27
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
`ifdef BSG_PIPE_DFF_FLUSH_EN
    input  logic               flush_i,
`endif
    input  logic               up_v_i,
    input  logic [width_p-1:0] up_data_i,
    input  logic               down_adv_i,
    output logic               adv_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o
);
    typedef struct packed {
        logic               v;
        logic [width_p-1:0] data;
    } stage_t;

    stage_t state_q;
    stage_t state_d;

    // An empty stage always advances, so bubbles collapse under a stalled tail.
    assign adv_o  = ~state_q.v | down_adv_i;
    assign v_o    = state_q.v;
    assign data_o = state_q.data;

    // Next-state: load from upstream on advance; data only moves with a valid item.
    always_comb begin
        state_d = state_q;
`ifdef BSG_PIPE_DFF_FLUSH_EN
        if (flush_i) begin
            state_d.v = 1'b0;
        end else
`endif
        if (adv_o) begin
            state_d.v = up_v_i;
            if (up_v_i) begin
                state_d.data = up_data_i;
            end else begin
                state_d.data = state_q.data;
            end
        end else begin
            state_d = state_q;
        end
    end

    // Stage register with asynchronous clear.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= '0;
        end else begin
            state_q <= state_d;
        end
    end
endmodule

// File: rtl/bsg_pipe_dff.sv
// Bubble-collapsing chain of depth_p register stages with occupancy counter.
// Define BSG_PIPE_DFF_FLUSH_EN to add the synchronous flush_i input.
module bsg_pipe_dff
    import bsg_pipe_dff_pkg::*;
#(
    parameter int width_p  = 27,
    parameter int depth_p  = 3,
    parameter int harden_p = 0
) (
    input  logic clk_i,
    input  logic reset_n_i,
`ifdef BSG_PIPE_DFF_FLUSH_EN
    input  logic flush_i,
`endif
    bsg_pipe_dff_if.slave io
);
    localparam int count_w_lp = count_width(depth_p);

    logic [depth_p-1:0]    v_s;
    logic [width_p-1:0]    data_s [depth_p];
    logic [depth_p:0]      adv_s;
    logic                  enq_s;
    logic                  deq_s;
    logic [count_w_lp-1:0] count_q;
    logic [count_w_lp-1:0] count_d;

    // Hardened mapping has no functional effect; both branches are the same chain.
    if (harden_p != 0) begin : g_hard_map
    end else begin : g_soft_map
    end

    assign adv_s[depth_p] = io.yumi_i;

    for (genvar k = 0; k < depth_p; k++) begin : g_stage
        logic               up_v_s;
        logic [width_p-1:0] up_data_s;

        if (k == 0) begin : g_head
            assign up_v_s    = io.v_i;
            assign up_data_s = io.data_i;
        end else begin : g_body
            assign up_v_s    = v_s[k-1];
            assign up_data_s = data_s[k-1];
        end

        bsg_pipe_dff_stage #(
            .width_p    (width_p)
        ) u_stage (
            .clk_i      (clk_i),
            .reset_n_i  (reset_n_i),
`ifdef BSG_PIPE_DFF_FLUSH_EN
            .flush_i    (flush_i),
`endif
            .up_v_i     (up_v_s),
            .up_data_i  (up_data_s),
            .down_adv_i (adv_s[k+1]),
            .adv_o      (adv_s[k]),
            .v_o        (v_s[k]),
            .data_o     (data_s[k])
        );
    end

`ifdef BSG_PIPE_DFF_FLUSH_EN
    assign io.ready_o = adv_s[0] & ~flush_i;
`else
    assign io.ready_o = adv_s[0];
`endif

    assign enq_s      = io.v_i & io.ready_o;
    assign deq_s      = io.yumi_i & v_s[depth_p-1];
    assign io.v_o     = v_s[depth_p-1];
    assign io.data_o  = data_s[depth_p-1];
    assign io.count_o = count_q;

    // Occupancy: +1 on enqueue only, -1 on dequeue only, flush empties it.
    always_comb begin
        count_d = count_q;
`ifdef BSG_PIPE_DFF_FLUSH_EN
        if (flush_i) begin
            count_d = '0;
        end else
`endif
        begin
            case ({enq_s, deq_s})
                2'b10:   count_d = count_q + count_w_lp'(1);
                2'b01:   count_d = count_q - count_w_lp'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Occupancy register with asynchronous clear.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    bsg_pipe_dff_chk #(
        .depth_p   (depth_p),
        .count_w_p (count_w_lp)
    ) u_chk (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .yumi_i    (io.yumi_i),
        .v_o       (v_s[depth_p-1]),
        .v_vec_i   (v_s),
        .count_i   (count_q)
    );
endmodule

// File: tb/tb_bsg_pipe_dff.sv
// Directed and randomized bench for bsg_pipe_dff (depth 3 and depth 1 instances).
module tb_bsg_pipe_dff;
    logic clk;
    logic rst_n;
    logic yumi_en3;
    int   checks;
    int   failures;

    bsg_pipe_dff_if #(.width_p(27), .depth_p(3)) if3 ();
    bsg_pipe_dff_if #(.width_p(1),  .depth_p(1)) if1 ();

`ifdef BSG_PIPE_DFF_FLUSH_EN
    logic flush3;
    logic flush1;
`endif

    // Consume only when the stage-2 item is visible, keeping the yumi protocol legal.
    assign if3.yumi_i = yumi_en3 & if3.v_o;

    bsg_pipe_dff #(.width_p(27), .depth_p(3), .harden_p(0)) dut3 (
        .clk_i     (clk),
        .reset_n_i (rst_n),
`ifdef BSG_PIPE_DFF_FLUSH_EN
        .flush_i   (flush3),
`endif
        .io        (if3.slave)
    );

    bsg_pipe_dff #(.width_p(1), .depth_p(1), .harden_p(0)) dut1 (
        .clk_i     (clk),
        .reset_n_i (rst_n),
`ifdef BSG_PIPE_DFF_FLUSH_EN
        .flush_i   (flush1),
`endif
        .io        (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [26:0] exp3 [3];
        logic        q [$];
        logic        vi;
        logic        di;
        logic        yi;
        logic        exp_ready;

        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        yumi_en3 = 1'b0;
        if3.v_i = 1'b0;
        if3.data_i = 27'h0;
        if1.v_i = 1'b0;
        if1.data_i = 1'b0;
        if1.yumi_i = 1'b0;
`ifdef BSG_PIPE_DFF_FLUSH_EN
        flush3 = 1'b0;
        flush1 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #2;
        chk("rst_v_o",   64'(if3.v_o), 64'd0);
        chk("rst_count", 64'(if3.count_o), 64'd0);
        chk("rst_data",  64'(if3.data_o), 64'd0);
        chk("rst_ready", 64'(if3.ready_o), 64'd1);

        // Stream 1,2,3 with consumer enabled; first item offered while reset releases.
        yumi_en3 = 1'b1;
        if3.v_i = 1'b1;
        if3.data_i = 27'h1;
        rst_n = 1'b1;
        tick();
        if3.data_i = 27'h2;
        tick();
        if3.data_i = 27'h3;
        tick();
        if3.v_i = 1'b0;
        exp3[0] = 27'h1;
        exp3[1] = 27'h2;
        exp3[2] = 27'h3;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("stream_v_o",   64'(if3.v_o), 64'd1);
            chk("stream_data",  64'(if3.data_o), 64'(exp3[i]));
            chk("stream_count", 64'(if3.count_o), 64'(3 - i));
            tick();
        end
        chk("stream_empty_v", 64'(if3.v_o), 64'd0);
        chk("stream_empty_c", 64'(if3.count_o), 64'd0);

        // Fill without consumer, then a fourth attempt must be refused.
        yumi_en3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if3.v_i = 1'b1;
            if3.data_i = 27'hA + 27'(i);
            #1;
            chk("fill_ready", 64'(if3.ready_o), 64'd1);
            tick();
        end
        if3.data_i = 27'hD;
        #1;
        chk("full_ready",  64'(if3.ready_o), 64'd0);
        chk("full_count",  64'(if3.count_o), 64'd3);
        tick();
        chk("full_hold_c", 64'(if3.count_o), 64'd3);
        chk("full_hold_d", 64'(if3.data_o), 64'hA);
        yumi_en3 = 1'b1;
        #1;
        chk("full_yumi_ready", 64'(if3.ready_o), 64'd1);
        tick();
        if3.v_i = 1'b0;
        chk("full_swap_count", 64'(if3.count_o), 64'd3);
        chk("full_swap_data",  64'(if3.data_o), 64'hB);
        tick();
        chk("drain_c1", 64'(if3.data_o), 64'hC);
        chk("drain_n1", 64'(if3.count_o), 64'd2);
        tick();
        chk("drain_d1", 64'(if3.data_o), 64'hD);
        chk("drain_n2", 64'(if3.count_o), 64'd1);
        tick();
        chk("drain_v0", 64'(if3.v_o), 64'd0);
        chk("drain_n3", 64'(if3.count_o), 64'd0);

        // Bubble collapse: item, two idle cycles, second item against a stalled tail.
        yumi_en3 = 1'b0;
        if3.v_i = 1'b1;
        if3.data_i = 27'h11;
        tick();
        if3.v_i = 1'b0;
        tick();
        tick();
        chk("bub_first_v", 64'(if3.v_o), 64'd1);
        chk("bub_first_d", 64'(if3.data_o), 64'h11);
        if3.v_i = 1'b1;
        if3.data_i = 27'h22;
        tick();
        if3.v_i = 1'b0;
        tick();
        chk("bub_count", 64'(if3.count_o), 64'd2);
        chk("bub_data",  64'(if3.data_o), 64'h11);
        chk("bub_ready", 64'(if3.ready_o), 64'd1);
        yumi_en3 = 1'b1;
        tick();
        yumi_en3 = 1'b0;
        chk("bub_stage1_d", 64'(if3.data_o), 64'h22);
        chk("bub_stage1_c", 64'(if3.count_o), 64'd1);
        if3.v_i = 1'b1;
        if3.data_i = 27'h33;
        tick();
        if3.v_i = 1'b0;
        chk("pre_rst_count", 64'(if3.count_o), 64'd2);

        // Asynchronous reset between edges.
        rst_n = 1'b0;
        #1;
        chk("arst_v_o",   64'(if3.v_o), 64'd0);
        chk("arst_count", 64'(if3.count_o), 64'd0);
        chk("arst_data",  64'(if3.data_o), 64'd0);
        chk("arst_ready", 64'(if3.ready_o), 64'd1);
        #1;
        rst_n = 1'b1;
        tick();

`ifdef BSG_PIPE_DFF_FLUSH_EN
        for (int i = 0; i < 3; i++) begin
            if3.v_i = 1'b1;
            if3.data_i = 27'h31 + 27'(i);
            tick();
        end
        if3.data_i = 27'h44;
        flush3 = 1'b1;
        #1;
        chk("flush_ready",  64'(if3.ready_o), 64'd0);
        chk("flush_pre_c",  64'(if3.count_o), 64'd3);
        tick();
        flush3 = 1'b0;
        if3.v_i = 1'b0;
        chk("flush_count",  64'(if3.count_o), 64'd0);
        chk("flush_v_o",    64'(if3.v_o), 64'd0);
        chk("flush_data",   64'(if3.data_o), 64'h31);
        tick();
        tick();
        tick();
        chk("flush_noenq_v", 64'(if3.v_o), 64'd0);
        chk("flush_noenq_c", 64'(if3.count_o), 64'd0);
`endif

        // Depth-1 random run against a reference queue.
        for (int c = 0; c < 10000; c++) begin
            vi = 1'($urandom_range(0, 1));
            di = 1'($urandom_range(0, 1));
            yi = (q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            if1.v_i = vi;
            if1.data_i = di;
            if1.yumi_i = yi;
            #1;
            exp_ready = (q.size() < 1) || yi;
            chk("rnd_ready", 64'(if1.ready_o), 64'(exp_ready));
            chk("rnd_v_o",   64'(if1.v_o), 64'(q.size() > 0));
            chk("rnd_count", 64'(if1.count_o), 64'(q.size()));
            chk("rnd_cmax",  64'(if1.count_o <= 1'b1), 64'd1);
            if (q.size() > 0) begin
                chk("rnd_data", 64'(if1.data_o), 64'(q[0]));
            end
            @(posedge clk);
            if (yi) begin
                void'(q.pop_front());
            end
            if (vi && exp_ready) begin
                q.push_back(di);
            end
            #2;
        end
        if1.v_i = 1'b0;
        if1.yumi_i = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
